uart_rx_queue: RTL and testbench

- Sits between `uart_rx` (BLE receive) and the servant RAM Wishbone port.
- Buffers received bytes in a small FIFO so no byte is lost while the CPU owns the bus.
- Drains bytes into a word-aligned ring buffer in RAM, using the bus only when the CPU is idle.
- Passes CPU accesses through to RAM and arbitrates between the two masters.

---
 rtl/uart_rxq_pkg.sv | 23 ++
 rtl/uart_rxq_fifo.sv | 74 +++++++
 rtl/uart_rx_queue.sv | 150 +++++++++++++++
 tb/tb_uart_rx_queue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rxq_pkg.sv
// Shared types and constants for the UART receive queue: arbiter state
// encoding, byte width, ring step and the ring-pointer advance helper.
package uart_rxq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CPU  = 2'd1,
      S_QWR  = 2'd2
   } state_e;

   localparam int BYTE_W    = 8;
   localparam int WORD_STEP = 4;

   // Next ring address: one word on, wrapping back to the base past the top.
   function automatic logic [31:0] ring_next(input logic [31:0] ptr,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
      logic [31:0] nxt;
      nxt = ptr + WORD_STEP;
      return (nxt > hi) ? lo : nxt;
   endfunction

endpackage

// File: rtl/uart_rxq_fifo.sv
// Byte FIFO between the UART receiver and the RAM drain. Push and pop may
// coincide, so a push into a full FIFO is still accepted when the head is
// leaving in the same cycle; otherwise it is dropped and o_drop pulses.
module uart_rxq_fifo
   import uart_rxq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_push,
   input  logic [BYTE_W-1:0]       i_dat,
   input  logic                    i_pop,
   output logic [BYTE_W-1:0]       o_dat,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_empty,
   output logic                    o_full,
   output logic                    o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              push_ok, pop_ok;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == FULL_CNT);
   assign o_level = count_q;
   assign o_dat   = mem[rd_ptr_q];

   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);
   assign o_drop  = i_push && o_full && !pop_ok;

   // Next pointers and occupancy from the accepted push/pop pair.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset flushes the queue.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!i_rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write on every accepted push.
   always_ff @(posedge i_clk) begin
      // NOTE: the array is deliberately not reset; entries are only read behind a valid count.
      if (push_ok) mem[wr_ptr_q] <= i_dat;
   end

endmodule

// File: rtl/uart_rx_queue.sv
// Receive-byte queue between uart_rx and the RAM Wishbone port. Bytes are
// buffered and written one per word into a ring in RAM whenever the CPU is
// not using the bus; CPU accesses pass straight through otherwise.
// Optional: define UART_RXQ_DROP_CNT_EN to add a saturating drop counter
// (o_drop_cnt); o_overflow then reports a non-zero count.
module uart_rx_queue
   import uart_rxq_pkg::*;
#(
   parameter int          DEPTH  = 8,
   parameter logic [31:0] ADR_LL = 32'h300,
   parameter logic [31:0] ADR_UL = 32'h1FFC
) (
   input  logic                    i_wb_clk,
   input  logic                    i_wb_rst_n,
   input  logic                    i_rx_done,
   input  logic [7:0]              i_rx_dat,
   input  logic [31:0]             i_cpu_adr,
   input  logic                    i_cpu_cyc,
   input  logic                    i_cpu_we,
   input  logic [3:0]              i_cpu_sel,
   input  logic [31:0]             i_cpu_dat,
   output logic [31:0]             o_cpu_rdt,
   output logic                    o_cpu_ack,
   output logic [31:0]             o_ram_adr,
   output logic                    o_ram_cyc,
   output logic                    o_ram_we,
   output logic [3:0]              o_ram_sel,
   output logic [31:0]             o_ram_dat,
   input  logic [31:0]             i_ram_rdt,
   input  logic                    i_ram_ack,
   output logic [31:0]             o_wr_ptr,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_empty,
   output logic                    o_full,
   output logic                    o_overflow
`ifdef UART_RXQ_DROP_CNT_EN
   ,
   output logic [15:0]             o_drop_cnt
`endif
);

   state_e            state_q, state_d;
   logic [31:0]       wr_ptr_q, wr_ptr_d;
   logic              fifo_pop, fifo_drop;
   logic [BYTE_W-1:0] fifo_dat;

   uart_rxq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_wb_clk),
      .i_rst_n (i_wb_rst_n),
      .i_push  (i_rx_done),
      .i_dat   (i_rx_dat),
      .i_pop   (fifo_pop),
      .o_dat   (fifo_dat),
      .o_level (o_level),
      .o_empty (o_empty),
      .o_full  (o_full),
      .o_drop  (fifo_drop)
   );

   assign o_cpu_rdt = i_ram_rdt;
   assign o_wr_ptr  = wr_ptr_q;

   // Arbiter: CPU wins when both are pending; each queue write returns to IDLE.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_cpu_cyc && !i_ram_ack)   state_d = S_CPU;
            else if (!i_cpu_cyc && !o_empty) state_d = S_QWR;
         end
         S_CPU: begin
            if (i_ram_ack) state_d = S_IDLE;
         end
         S_QWR: begin
            if (i_ram_ack) begin
               fifo_pop = 1'b1;
               wr_ptr_d = ring_next(wr_ptr_q, ADR_LL, ADR_UL);
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus mux: the queue owns RAM only in QWR, and the CPU sees no ack then.
   always_comb begin
      o_ram_adr = i_cpu_adr;
      o_ram_cyc = i_cpu_cyc;
      o_ram_we  = i_cpu_we;
      o_ram_sel = i_cpu_sel;
      o_ram_dat = i_cpu_dat;
      o_cpu_ack = i_ram_ack;
      if (state_q == S_QWR) begin
         o_ram_adr = wr_ptr_q;
         o_ram_cyc = 1'b1;
         o_ram_we  = 1'b1;
         o_ram_sel = 4'b1111;
         o_ram_dat = {24'b0, fifo_dat};
         o_cpu_ack = 1'b0;
      end
   end

   // Arbiter state and ring pointer; reset abandons any queue write in flight.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= ADR_LL;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

`ifdef UART_RXQ_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign o_drop_cnt = drop_cnt_q;
   assign o_overflow = (drop_cnt_q != 16'd0);

   // Saturating count of dropped bytes.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (fifo_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) drop_cnt_q <= 16'd0;
      else             drop_cnt_q <= drop_cnt_d;
   end
`else
   logic overflow_q, overflow_d;

   assign o_overflow = overflow_q;

   // Sticky overflow flag set by any dropped byte.
   always_comb begin
      overflow_d = overflow_q | fifo_drop;
   end

   // Overflow register, cleared only by reset.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) overflow_q <= 1'b0;
      else             overflow_q <= overflow_d;
   end
`endif

endmodule

// File: tb/tb_uart_rx_queue.sv
// Directed bench for uart_rx_queue: a one-cycle-latency RAM responder, a log
// of completed RAM writes, and a linear sequence of steps checked at negedge.
module tb_uart_rx_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_rx_done;
   logic [7:0]  i_rx_dat;
   logic [31:0] i_cpu_adr;
   logic        i_cpu_cyc;
   logic        i_cpu_we;
   logic [3:0]  i_cpu_sel;
   logic [31:0] i_cpu_dat;
   logic [31:0] o_cpu_rdt;
   logic        o_cpu_ack;
   logic [31:0] o_ram_adr;
   logic        o_ram_cyc;
   logic        o_ram_we;
   logic [3:0]  o_ram_sel;
   logic [31:0] o_ram_dat;
   logic [31:0] i_ram_rdt;
   logic        i_ram_ack;
   logic [31:0] o_wr_ptr;
   logic [3:0]  o_level;
   logic        o_empty;
   logic        o_full;
   logic        o_overflow;
`ifdef UART_RXQ_DROP_CNT_EN
   logic [15:0] o_drop_cnt;
`endif

   logic ram_ack_en;
   int   n_checks = 0;
   int   n_errors = 0;
   int   bad_ack  = 0;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;
   wr_t wr_q[$];

   uart_rx_queue dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .i_rx_done  (i_rx_done),
      .i_rx_dat   (i_rx_dat),
      .i_cpu_adr  (i_cpu_adr),
      .i_cpu_cyc  (i_cpu_cyc),
      .i_cpu_we   (i_cpu_we),
      .i_cpu_sel  (i_cpu_sel),
      .i_cpu_dat  (i_cpu_dat),
      .o_cpu_rdt  (o_cpu_rdt),
      .o_cpu_ack  (o_cpu_ack),
      .o_ram_adr  (o_ram_adr),
      .o_ram_cyc  (o_ram_cyc),
      .o_ram_we   (o_ram_we),
      .o_ram_sel  (o_ram_sel),
      .o_ram_dat  (o_ram_dat),
      .i_ram_rdt  (i_ram_rdt),
      .i_ram_ack  (i_ram_ack),
      .o_wr_ptr   (o_wr_ptr),
      .o_level    (o_level),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_overflow (o_overflow)
`ifdef UART_RXQ_DROP_CNT_EN
      ,
      .o_drop_cnt (o_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // RAM responder: ack one cycle after cyc, read data tagged with the address.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) i_ram_ack <= 1'b0;
      else        i_ram_ack <= o_ram_cyc && !i_ram_ack && ram_ack_en;
   end
   assign i_ram_rdt = {16'hCAFE, o_ram_adr[15:0]};

   // Log every completed RAM write; flag any CPU ack given during a queue write.
   always @(posedge clk) begin
      wr_t w;
      if (rst_n && o_ram_cyc && o_ram_we && i_ram_ack) begin
         w.adr = o_ram_adr;
         w.dat = o_ram_dat;
         w.sel = o_ram_sel;
         wr_q.push_back(w);
      end
      if (o_cpu_ack && o_ram_we && !i_cpu_we) bad_ack++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [31:0] adr, input logic [7:0] b);
      wr_t w;
      w.adr = 32'hX; w.dat = 32'hX; w.sel = 4'hX;
      if (idx < wr_q.size()) w = wr_q[idx];
      check({tag, " adr"}, w.adr, adr);
      check({tag, " dat"}, w.dat, {24'h0, b});
      check({tag, " sel"}, {28'h0, w.sel}, 32'hF);
   endtask

   task automatic push_byte(input logic [7:0] b);
      i_rx_dat  = b;
      i_rx_done = 1'b1;
      @(negedge clk);
      i_rx_done = 1'b0;
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while (!(o_empty && !o_ram_cyc) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, " drained"}, 32'(o_empty && !o_ram_cyc), 32'd1);
   endtask

   // Wait for the CPU ack, then end the CPU cycle at that same point.
   task automatic cpu_release(input string tag);
      int n = 0;
      while (!o_cpu_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " cpu ack"}, 32'(o_cpu_ack), 32'd1);
      i_cpu_cyc = 1'b0;
   endtask

   task automatic wait_qwr(input string tag);
      int n = 0;
      while (!(o_ram_cyc && o_ram_we) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " in qwr"}, 32'(o_ram_cyc && o_ram_we), 32'd1);
   endtask

   task automatic cpu_hold();
      i_cpu_adr = 32'h100;
      i_cpu_we  = 1'b0;
      i_cpu_sel = 4'hF;
      i_cpu_cyc = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      ram_ack_en = 1'b1;
      i_rx_done  = 1'b0;
      i_rx_dat   = 8'h00;
      i_cpu_adr  = 32'h0;
      i_cpu_cyc  = 1'b0;
      i_cpu_we   = 1'b0;
      i_cpu_sel  = 4'h0;
      i_cpu_dat  = 32'h0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst level",    32'(o_level),    32'd0);
      check("rst empty",    32'(o_empty),    32'd1);
      check("rst full",     32'(o_full),     32'd0);
      check("rst overflow", 32'(o_overflow), 32'd0);
      check("rst wr_ptr",   o_wr_ptr,        32'h300);
      check("rst ram_cyc",  32'(o_ram_cyc),  32'd0);
      check("rst cpu_ack",  32'(o_cpu_ack),  32'd0);
`ifdef UART_RXQ_DROP_CNT_EN
      check("rst drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Three bytes with the CPU idle
      push_byte(8'h41);
      push_byte(8'h42);
      push_byte(8'h43);
      wait_drained("t1");
      check("t1 writes", wr_q.size(), 32'd3);
      check_wr("t1 w0", 0, 32'h300, 8'h41);
      check_wr("t1 w1", 1, 32'h304, 8'h42);
      check_wr("t1 w2", 2, 32'h308, 8'h43);
      check("t1 wr_ptr", o_wr_ptr, 32'h30C);
      check("t1 empty", 32'(o_empty), 32'd1);
      wr_q.delete();

      // Fresh pointer, then CPU read racing a received byte
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cpu_hold();
      push_byte(8'h55);
      check("t2 cpu first", wr_q.size(), 32'd0);
      check("t2 cpu ack", 32'(o_cpu_ack), 32'd1);
      check("t2 cpu rdt", o_cpu_rdt, 32'hCAFE0100);
      cpu_release("t2");
      wait_drained("t2");
      check("t2 writes", wr_q.size(), 32'd1);
      check_wr("t2 w0", 0, 32'h300, 8'h55);
      check("t2 wr_ptr", o_wr_ptr, 32'h304);
      check("t2 no ack in qwr", bad_ack, 32'd0);
      wr_q.delete();

      // Walk the pointer to the top word, then wrap
      for (int k = 0; k < 1854; k++) begin
         push_byte(8'(k));
         wait_drained("t4 fill");
      end
      wr_q.delete();
      check("t4 ptr top", o_wr_ptr, 32'h1FFC);
      push_byte(8'hA5);
      wait_drained("t4");
      check("t4 writes", wr_q.size(), 32'd1);
      check_wr("t4 top", 0, 32'h1FFC, 8'hA5);
      check("t4 wrapped", o_wr_ptr, 32'h300);
      wr_q.delete();

      // Full FIFO in QWR: push coinciding with the popping ack
      cpu_hold();
      for (int k = 0; k < 8; k++) push_byte(8'h70 + 8'(k));
      check("t5 full", 32'(o_full), 32'd1);
      check("t5 level", 32'(o_level), 32'd8);
      check("t5 overflow", 32'(o_overflow), 32'd0);
      cpu_release("t5");
      ram_ack_en = 1'b0;
      wait_qwr("t5");
      ram_ack_en = 1'b1;
      @(negedge clk);
      check("t5 full pre", 32'(o_full), 32'd1);
      i_rx_dat  = 8'h78;
      i_rx_done = 1'b1;
      @(negedge clk);
      i_rx_done = 1'b0;
      check("t5 level kept", 32'(o_level), 32'd8);
      check("t5 overflow kept", 32'(o_overflow), 32'd0);
      check("t5 first write", wr_q.size(), 32'd1);
      wait_drained("t5");
      check("t5 writes", wr_q.size(), 32'd9);
      for (int k = 0; k < 9; k++)
         check_wr("t5 w", k, 32'h300 + 32'(4 * k), 8'h70 + 8'(k));
      check("t5 wr_ptr", o_wr_ptr, 32'h324);
      wr_q.delete();

      // Overflow: DEPTH+2 bytes while the CPU holds the bus
      cpu_hold();
      for (int k = 0; k < 10; k++) push_byte(8'h60 + 8'(k));
      check("t3 full", 32'(o_full), 32'd1);
      check("t3 level", 32'(o_level), 32'd8);
      check("t3 overflow", 32'(o_overflow), 32'd1);
`ifdef UART_RXQ_DROP_CNT_EN
      check("t3 drop_cnt", 32'(o_drop_cnt), 32'd2);
`endif
      check("t3 no drain", wr_q.size(), 32'd0);
      cpu_release("t3");
      wait_drained("t3");
      check("t3 writes", wr_q.size(), 32'd8);
      for (int k = 0; k < 8; k++)
         check_wr("t3 w", k, 32'h324 + 32'(4 * k), 8'h60 + 8'(k));
      check("t3 wr_ptr", o_wr_ptr, 32'h344);
      check("t3 overflow sticky", 32'(o_overflow), 32'd1);
      check("t3 no ack in qwr", bad_ack, 32'd0);
      wr_q.delete();

      // Reset while a queue write is pending
      cpu_hold();
      push_byte(8'h90);
      push_byte(8'h91);
      push_byte(8'h92);
      cpu_release("t6");
      ram_ack_en = 1'b0;
      wait_qwr("t6");
      rst_n = 1'b0;
      #1;
      check("t6 ram_cyc", 32'(o_ram_cyc), 32'd0);
      check("t6 empty", 32'(o_empty), 32'd1);
      check("t6 level", 32'(o_level), 32'd0);
      check("t6 wr_ptr", o_wr_ptr, 32'h300);
      check("t6 overflow", 32'(o_overflow), 32'd0);
`ifdef UART_RXQ_DROP_CNT_EN
      check("t6 drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
      @(negedge clk);
      rst_n      = 1'b1;
      ram_ack_en = 1'b1;
      repeat (3) @(negedge clk);
      check("t6 idle cyc", 32'(o_ram_cyc), 32'd0);
      check("t6 idle empty", 32'(o_empty), 32'd1);
      check("t6 no write", wr_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
